mio_bus_responder: RTL and testbench
====================================

Name: mio_bus_responder

Overview:
- Memory/IO responder on the far end of the CPU data-bus handshake.
- Accepts a request strobe (CPU_MIO) with address, write data and MemWrite from the single-cycle core.
- Serves a word-addressed data RAM and a small peripheral register file.
- Returns read data with MIO_ready after a programmable number of wait states; also drives the core's INT line from a compare timer.

Parameters:
- ADDR_W, 10: RAM depth is 2^ADDR_W 32-bit words.
- WAIT_CYC, 2: wait states between accept and response, legal range 0..15.
- LED_W, 16: width of the LED output register and the switch input.

Ports:
- clk  in  1: system clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- CPU_MIO  in  1: request strobe. Held high by the core until MIO_ready.
- MemWrite  in  1: 1 = write, 0 = read. Sampled at accept.
- addr  in  32: byte address from the core ALU output.
- wdata  in  32: write data.
- rdata  out  32: read data. Valid only while MIO_ready=1.
- MIO_ready  out  1: one-cycle response pulse.
- sw  in  LED_W: switch inputs. Read-only register.
- led  out  LED_W: LED register.
- INT  out  1: timer interrupt, level, sticky.

Behaviour:
- Reset (rst=0, async): state IDLE, rdata=0, MIO_ready=0, led=0, INT=0, timer count=0, compare=0. RAM contents undefined (not cleared).
- Address map, decoded from the latched address; addr[1:0] ignored:
  - addr[31:28]=0x0: RAM, word index addr[ADDR_W+1:2].
  - 0xE000_0000: LED, R/W; low LED_W bits used, upper bits read 0.
  - 0xE000_0004: switch, RO; writes dropped.
  - 0xE000_0008: timer count, RO.
  - 0xE000_000C: compare, R/W; a write also clears INT.
  - Anything else: reads return 0, writes dropped.
- FSM states:
  - IDLE, MIO_ready=0: when CPU_MIO=1, latch addr/wdata/MemWrite. If WAIT_CYC=0 go to RESP, else load wait counter with WAIT_CYC and go to WAIT.
  - WAIT: decrement counter each cycle; at counter==1 go to RESP. If CPU_MIO drops while in WAIT, abort: return to IDLE, no write, no ready.
  - RESP: MIO_ready=1 for exactly one cycle, rdata driven with the selected data, write committed on this clock edge. Always return to IDLE.
- Latency: ready is asserted WAIT_CYC+1 cycles after the accept edge.
- CPU_MIO still high in the cycle after RESP starts a new transaction, since IDLE samples it. The core must drop CPU_MIO on the ready edge.
- Read during RESP returns pre-write contents (the transaction is either a read or a write, never both).
- RAM is synchronous read: address registered at the last WAIT/accept edge, data valid in RESP.
- Timer: 32-bit count increments every clk and wraps 0xFFFF_FFFF -> 0. INT is set when count==compare and compare!=0.
- Simultaneous INT set and clear-by-write: set wins.
- Reset mid-transaction aborts it; no write occurs.

Optional Feature:
- Macro MIO_BYTE_WRITE_EN.
- Defined: adds input be[3:0]. RAM and LED writes update only the bytes whose be bit is 1; be is latched at accept; be=0000 behaves as a write with no effect but still returns ready. Compare writes ignore be (full word).
- Undefined: no be port; all writes are full-word.

Test Plan:
- Write RAM 0x0000_0010 = 0xDEAD_BEEF, then read it back, WAIT_CYC=2 -> ready exactly 3 cycles after each accept edge; rdata=0xDEAD_BEEF.
- WAIT_CYC=0: read 0xE000_0004 with sw=0x00A5 -> ready on the cycle after accept; rdata=0x0000_00A5.
- Write 0xE000_0000 = 0x1234_5678 -> led=0x5678; read-back gives 0x0000_5678. Write to 0x7000_0000 then read it back -> 0.
- Start a write, drop CPU_MIO in WAIT -> no ready; RAM unchanged; next request accepted normally.
- Compare=20 after reset -> INT rises when count=20 and stays high; write compare=0 -> INT cleared next cycle.
- With MIO_BYTE_WRITE_EN: RAM word 0x1111_1111, write 0xAABB_CCDD with be=0101 -> readback 0x11BB_11DD.

Source files
------------

// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the core's CPU_MIO handshake: word RAM, LED/switch/timer registers, timer INT.
// Optional MIO_BYTE_WRITE_EN adds a be[3:0] byte-enable input for RAM and LED writes.
module mio_bus_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2,
  parameter int LED_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPU_MIO,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
`ifdef MIO_BYTE_WRITE_EN
  input  logic [3:0]        be,
`endif
  output logic [31:0]       rdata,
  output logic              MIO_ready,
  input  logic [LED_W-1:0]  sw,
  output logic [LED_W-1:0]  led,
  output logic              INT
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t      state, state_d;
  logic [3:0]  wcnt;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [3:0]  be_eff;
  logic [31:0] bmask;
  logic [31:0] cnt, cmp;
  logic [31:0] rsel;
  logic        accept, commit;
  logic        sel_ram, sel_led, sel_sw, sel_cnt, sel_cmp;

  assign accept = (state == S_IDLE) && CPU_MIO;
  assign commit = (state == S_RESP) && we_q;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (CPU_MIO) state_d = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        // A dropped strobe wins over the terminal count.
        if (!CPU_MIO)        state_d = S_IDLE;
        else if (wcnt == 4'd1) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        wcnt    <= WAIT_LD;
        addr_q  <= addr[31:2];
        wdata_q <= wdata;
        we_q    <= MemWrite;
`ifdef MIO_BYTE_WRITE_EN
        be_q    <= be;
`else
        be_q    <= 4'hF;
`endif
      end else if (state == S_WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

  assign be_eff = be_q;
  assign bmask  = {{8{be_eff[3]}}, {8{be_eff[2]}}, {8{be_eff[1]}}, {8{be_eff[0]}}};

  assign sel_ram = (addr_q[31:28] == 4'h0);
  assign sel_led = ({addr_q, 2'b00} == 32'hE000_0000);
  assign sel_sw  = ({addr_q, 2'b00} == 32'hE000_0004);
  assign sel_cnt = ({addr_q, 2'b00} == 32'hE000_0008);
  assign sel_cmp = ({addr_q, 2'b00} == 32'hE000_000C);

  // Read address tracks the incoming request while idle so a zero-wait read still has data in RESP.
  logic [ADDR_W-1:0] rd_idx, wr_idx;
  logic [3:0][7:0]   ram_q;
  assign rd_idx = (state == S_IDLE) ? addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
  assign wr_idx = addr_q[ADDR_W+1:2];

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
      ram_q[b] <= mem[rd_idx];
      if (commit && sel_ram && be_eff[b]) mem[wr_idx] <= wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= '0;
      cmp <= '0;
      cnt <= '0;
      INT <= 1'b0;
    end else begin
      cnt <= cnt + 32'd1;
      if (commit && sel_led)
        led <= (led & ~bmask[LED_W-1:0]) | (wdata_q[LED_W-1:0] & bmask[LED_W-1:0]);
      if (commit && sel_cmp) cmp <= wdata_q;
      // Match takes priority over the clear from a compare write.
      if (cnt == cmp && cmp != 32'd0) INT <= 1'b1;
      else if (commit && sel_cmp)     INT <= 1'b0;
    end
  end

  always_comb begin
    rsel = '0;
    if (sel_ram)      rsel = ram_q;
    else if (sel_led) rsel[LED_W-1:0] = led;
    else if (sel_sw)  rsel[LED_W-1:0] = sw;
    else if (sel_cnt) rsel = cnt;
    else if (sel_cmp) rsel = cmp;
  end

  assign MIO_ready = (state == S_RESP);
  assign rdata     = MIO_ready ? rsel : 32'd0;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], bmask};

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench: a WAIT_CYC=2 responder for most scenarios plus a WAIT_CYC=0 one for zero-wait reads.
module tb_mio_bus_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mio2 = 1'b0, mio0 = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [15:0] sw = '0;
  logic [31:0] rd2, rd0;
  logic        rdy2, rdy0;
  logic [15:0] led2, led0;
  logic        int2, int0;
`ifdef MIO_BYTE_WRITE_EN
  logic [3:0]  be = 4'hF;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] cyc;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 32'd1;

  mio_bus_responder #(.ADDR_W(10), .WAIT_CYC(2), .LED_W(16)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(mio2), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
`ifdef MIO_BYTE_WRITE_EN
    .be(be),
`endif
    .rdata(rd2), .MIO_ready(rdy2), .sw(sw), .led(led2), .INT(int2));

  mio_bus_responder #(.ADDR_W(10), .WAIT_CYC(0), .LED_W(16)) dut0 (
    .clk(clk), .rst(rst), .CPU_MIO(mio0), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
`ifdef MIO_BYTE_WRITE_EN
    .be(be),
`endif
    .rdata(rd0), .MIO_ready(rdy0), .sw(sw), .led(led0), .INT(int0));

  // Called at a negedge with the DUT idle; lat = cycles from accept edge to ready (0 = timeout).
  task automatic txn(input bit sel0, input bit we, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd);
    addr = a; wdata = d; MemWrite = we;
    if (sel0) mio0 = 1'b1; else mio2 = 1'b1;
    lat = 0; rd = 'x;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sel0 ? rdy0 : rdy2) begin
        lat = i; rd = sel0 ? rd0 : rd2;
        break;
      end
    end
    mio0 = 1'b0; mio2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", rdy2); end
    n_cmp++; if (rd2 !== 32'd0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", rd2); end
    n_cmp++; if (led2 !== 16'd0) begin n_err++; $display("FAIL reset_led got %h exp 0", led2); end
    n_cmp++; if (int2 !== 1'b0) begin n_err++; $display("FAIL reset_int got %b exp 0", int2); end
    n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %b exp 0", rdy0); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_rw;
    int lat; logic [31:0] rd, exp;
    txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL ram_wr_lat got %0d exp 3", lat); end
    sb.push_back(32'hDEAD_BEEF);
    txn(0, 0, 32'h0000_0010, 32'h0, lat, rd);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL ram_rd_lat got %0d exp 3", lat); end
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL ram_rd got %h exp %h", rd, exp); end
  endtask

  task automatic test_zero_wait;
    int lat; logic [31:0] rd, exp;
    sw = 16'h00A5;
    sb.push_back(32'h0000_00A5);
    txn(1, 0, 32'hE000_0004, 32'h0, lat, rd);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL zw_lat got %0d exp 1", lat); end
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL zw_sw_rd got %h exp %h", rd, exp); end
    // Switch register is read-only.
    txn(0, 1, 32'hE000_0004, 32'hFFFF_FFFF, lat, rd);
    sb.push_back(32'h0000_00A5);
    txn(0, 0, 32'hE000_0004, 32'h0, lat, rd);
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL sw_ro got %h exp %h", rd, exp); end
  endtask

  task automatic test_led_unmapped;
    int lat; logic [31:0] rd, exp;
    txn(0, 1, 32'hE000_0000, 32'h1234_5678, lat, rd);
    n_cmp++; if (led2 !== 16'h5678) begin n_err++; $display("FAIL led_out got %h exp 5678", led2); end
    sb.push_back(32'h0000_5678);
    txn(0, 0, 32'hE000_0000, 32'h0, lat, rd);
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL led_rd got %h exp %h", rd, exp); end
    txn(0, 1, 32'h7000_0000, 32'hCAFE_F00D, lat, rd);
    sb.push_back(32'h0);
    txn(0, 0, 32'h7000_0000, 32'h0, lat, rd);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL unmapped_lat got %0d exp 3", lat); end
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL unmapped_rd got %h exp %h", rd, exp); end
  endtask

  task automatic test_abort;
    int lat; logic [31:0] rd, exp; bit seen;
    txn(0, 1, 32'h0000_0020, 32'h0BAD_F00D, lat, rd);
    addr = 32'h0000_0020; wdata = 32'hFFFF_FFFF; MemWrite = 1'b1; mio2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    seen = rdy2;
    mio2 = 1'b0;
    repeat (6) begin @(negedge clk); if (rdy2) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_ready got %b exp 0", seen); end
    sb.push_back(32'h0BAD_F00D);
    txn(0, 0, 32'h0000_0020, 32'h0, lat, rd);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL post_abort_lat got %0d exp 3", lat); end
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL abort_ram got %h exp %h", rd, exp); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd, exp, d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      txn(0, 1, 32'h0000_0100 + 32'(4*i), d, lat, rd);
      sb.push_back(d);
    end
    for (int i = 0; i < 4; i++) begin
      txn(0, 0, 32'h0000_0100 + 32'(4*i), 32'h0, lat, rd);
      exp = sb.pop_front();
      n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL b2b_rd%0d got %h exp %h", i, rd, exp); end
    end
  endtask

  task automatic test_timer;
    int lat; logic [31:0] rd, exp, hit;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    txn(0, 1, 32'hE000_000C, 32'd20, lat, rd);
    n_cmp++; if (int2 !== 1'b0) begin n_err++; $display("FAIL int_early got %b exp 0", int2); end
    hit = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      if (int2) begin hit = cyc; break; end
      @(negedge clk);
    end
    n_cmp++; if (hit !== 32'd21) begin n_err++; $display("FAIL int_rise_cycle got %0d exp 21", hit); end
    repeat (5) @(negedge clk);
    n_cmp++; if (int2 !== 1'b1) begin n_err++; $display("FAIL int_sticky got %b exp 1", int2); end
    sb.push_back(cyc + 32'd3);
    txn(0, 0, 32'hE000_0008, 32'h0, lat, rd);
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL timer_rd got %h exp %h", rd, exp); end
    txn(0, 1, 32'hE000_000C, 32'd0, lat, rd);
    n_cmp++; if (int2 !== 1'b0) begin n_err++; $display("FAIL int_clear got %b exp 0", int2); end
  endtask

`ifdef MIO_BYTE_WRITE_EN
  task automatic test_byte_en;
    int lat; logic [31:0] rd, exp;
    be = 4'hF;
    txn(0, 1, 32'h0000_0040, 32'h1111_1111, lat, rd);
    be = 4'b0101;
    txn(0, 1, 32'h0000_0040, 32'hAABB_CCDD, lat, rd);
    be = 4'b0000;
    txn(0, 1, 32'h0000_0040, 32'h5555_5555, lat, rd);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL be0_lat got %0d exp 3", lat); end
    be = 4'hF;
    sb.push_back(32'h11BB_11DD);
    txn(0, 0, 32'h0000_0040, 32'h0, lat, rd);
    exp = sb.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL be_ram got %h exp %h", rd, exp); end
  endtask
`endif

  initial begin
    test_reset();
    test_ram_rw();
    test_zero_wait();
    test_led_unmapped();
    test_abort();
    test_back_to_back();
`ifdef MIO_BYTE_WRITE_EN
    test_byte_en();
`endif
    test_timer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
